// File: rtl/dmem_io_bus_pkg.sv
// Shared constants for the data-memory / memory-mapped I/O block.
// The same values are consumed by the software header generator, so the
// I/O offsets below are part of the CPU-visible address map.
package dmem_io_pkg;

    localparam int BUS_W        = 32;
    localparam int IO_OFF_W     = 5;
    localparam int OFF_OUT_BASE = 0;
    localparam int OFF_IN_BASE  = 8;
    localparam int OFF_STATUS   = 16;

    // Replace the byte lanes selected by be, keep the others.
    function automatic logic [BUS_W-1:0] lane_merge(
        input logic [BUS_W-1:0] old_w,
        input logic [BUS_W-1:0] new_w,
        input logic [3:0]       be
    );
        logic [BUS_W-1:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_io_bus_if.sv
// MEM-stage access bus between the CPU pipeline and dmem_io_bus.
//
// Handshake: there is no back-pressure. Every cycle with req = 1 is an
// accepted access (write when we = 1, read when we = 0). An accepted read
// is answered by rvalid = 1 with rdata in the cycle after the sampling
// edge; writes never raise rvalid. rdata holds its value between reads.
interface dmem_io_bus_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/dmem_io_bus_in_sync.sv
// Input-port synchroniser: two flops bring the asynchronous pin into the
// clock domain (s1 -> s2), and s3 keeps the previous s2 so a change of the
// synchronised value can be reported as a one-cycle pulse.
module dmem_in_sync #(
    parameter int IN_W = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] i_d,
    output logic [IN_W-1:0] o_q,
    output logic            o_chg
);

    logic [IN_W-1:0] r_s1;
    logic [IN_W-1:0] r_s2;
    logic [IN_W-1:0] r_s3;

    // Shift the pin value through s1, s2 and the history register s3.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_q   = r_s2;
    assign o_chg = (r_s2 != r_s3);

endmodule

// File: rtl/dmem_io_bus.sv
// Data memory with memory-mapped I/O for the MEM stage. The address bit just
// above the RAM word index selects the I/O window; inside it, addr[6:2] is
// the word offset into the output ports, synchronised input ports and the
// read-to-clear change-status register. Reads return one cycle later.
module dmem_io_bus
    import dmem_io_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int N_OUT  = 2,
    parameter int N_IN   = 2,
    parameter int IN_W   = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_io_bus_if.slave         bus,
    input  logic [N_IN*IN_W-1:0] in_port,
    output logic [N_OUT*32-1:0]  out_port
);

    logic [31:0]         r_mem [2**ADDR_W];
    logic [31:0]         r_out [N_OUT];
    logic [N_IN-1:0]     r_flags;
    logic [31:0]         r_rdata;
    logic                r_rvalid;

    logic                w_io_sel;
    logic [ADDR_W-1:0]   w_ram_idx;
    logic [IO_OFF_W-1:0] w_off;
    logic                w_acc_wr;
    logic                w_acc_rd;
    logic                w_stat_rd;
    logic [31:0]         w_rd_word;
    logic [IN_W-1:0]     w_in_val [N_IN];
    logic [N_IN-1:0]     w_chg;
    logic                w_unused;

    assign w_io_sel  = bus.addr[ADDR_W+2];
    assign w_ram_idx = bus.addr[ADDR_W+1:2];
    assign w_off     = bus.addr[IO_OFF_W+1:2];
    assign w_unused  = ^{bus.addr[31:ADDR_W+3], bus.addr[1:0]};

    // Reset in the same cycle as an access cancels it completely.
    assign w_acc_wr  = bus.req & bus.we & ~reset;
    assign w_acc_rd  = bus.req & ~bus.we & ~reset;
    assign w_stat_rd = w_acc_rd & w_io_sel & (w_off == IO_OFF_W'(OFF_STATUS));

    for (genvar g = 0; g < N_IN; g++) begin : g_in
        dmem_in_sync #(
            .IN_W (IN_W)
        ) u_sync (
            .clock (clock),
            .reset (reset),
            .i_d   (in_port[g*IN_W +: IN_W]),
            .o_q   (w_in_val[g]),
            .o_chg (w_chg[g])
        );
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_port[g*32 +: 32] = r_out[g];
    end

    // RAM word write with per-lane enables; contents are never reset.
    always_ff @(posedge clock) begin
        if (w_acc_wr && !w_io_sel) begin
            r_mem[w_ram_idx] <= lane_merge(r_mem[w_ram_idx], bus.wdata, bus.be);
        end
    end

    // Output-port registers, byte-lane writable at their I/O offsets.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_acc_wr && w_io_sel && (w_off == IO_OFF_W'(OFF_OUT_BASE + i))) begin
                    r_out[i] <= lane_merge(r_out[i], bus.wdata, bus.be);
                end
            end
        end
    end

    // Select the word a read at this edge returns; unmapped offsets read 0.
    always_comb begin
        w_rd_word = '0;
        if (!w_io_sel) begin
            w_rd_word = r_mem[w_ram_idx];
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_off == IO_OFF_W'(OFF_OUT_BASE + i)) begin
                    w_rd_word = r_out[i];
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                if (w_off == IO_OFF_W'(OFF_IN_BASE + i)) begin
                    w_rd_word = 32'(w_in_val[i]);
                end
            end
            if (w_off == IO_OFF_W'(OFF_STATUS)) begin
                w_rd_word = 32'(r_flags);
            end
        end
    end

    // Change flags: a status read clears, a coincident change event re-sets.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= (w_stat_rd ? '0 : r_flags) | w_chg;
        end
    end

    // Registered read data and its one-cycle valid strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_acc_rd;
            if (w_acc_rd) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_dmem_io_bus.sv
// Bench for dmem_io_bus: two instances, one with the default parameters and
// one with ADDR_W=8, N_OUT=4, N_IN=3, IN_W=16. Reads push their expected
// word into a per-instance queue; monitors pop on every rvalid.
module tb_dmem_io_bus;

    logic         clock = 1'b0;
    logic         reset;
    logic [19:0]  in_a;
    logic [63:0]  out_a;
    logic [47:0]  in_b;
    logic [127:0] out_b;

    logic [31:0]  exp_a[$];
    logic [31:0]  exp_b[$];
    logic [31:0]  e_a;
    logic [31:0]  e_b;
    int           checks = 0;
    int           errors = 0;

    always #5 clock = ~clock;

    dmem_io_bus_if bus_a ();
    dmem_io_bus_if bus_b ();

    dmem_io_bus #(
        .ADDR_W (5), .N_OUT (2), .N_IN (2), .IN_W (10)
    ) u_dut_a (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_a),
        .in_port  (in_a),
        .out_port (out_a)
    );

    dmem_io_bus #(
        .ADDR_W (8), .N_OUT (4), .N_IN (3), .IN_W (16)
    ) u_dut_b (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_b),
        .in_port  (in_b),
        .out_port (out_b)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_word(input int d, input int i);
        return (d == 0) ? out_a[i*32 +: 32] : out_b[i*32 +: 32];
    endfunction

    // One bus cycle on instance d, starting at a falling edge.
    task automatic op(input int d, input bit w, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        if (d == 0) begin
            bus_a.req = 1'b1; bus_a.we = w; bus_a.be = be; bus_a.addr = a; bus_a.wdata = wd;
            if (!w) exp_a.push_back(exp);
        end else begin
            bus_b.req = 1'b1; bus_b.we = w; bus_b.be = be; bus_b.addr = a; bus_b.wdata = wd;
            if (!w) exp_b.push_back(exp);
        end
        @(negedge clock);
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
    endtask

    task automatic wr(input int d, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        op(d, 1'b1, be, a, wd, 32'h0);
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp);
        op(d, 1'b0, 4'hF, a, 32'h0, exp);
    endtask

    task automatic set_in(input int d, input int i, input logic [31:0] v);
        if (d == 0) in_a[i*10 +: 10] = v[9:0];
        else        in_b[i*16 +: 16] = v[15:0];
    endtask

    task automatic suite(input int d);
        logic [31:0] io;
        logic [31:0] last;
        int          po;
        logic [31:0] v0;
        logic [31:0] v1;
        io   = (d == 0) ? 32'h80 : 32'h400;
        last = (d == 0) ? 32'h7C : 32'h3FC;
        po   = (d == 0) ? 1 : 3;
        v0   = (d == 0) ? 32'h3FF : 32'hBEEF;
        v1   = (d == 0) ? 32'h155 : 32'h0A5A;

        // RAM byte-lane merge
        wr(d, 4'hF, 32'h0, 32'h11223344);
        wr(d, 4'b0101, 32'h0, 32'hAABBCCDD);
        rd(d, 32'h0, 32'h11BB33DD);

        // Output port write, readback, and a write to an input offset
        wr(d, 4'hF, io + 32'(po*4), 32'hDEADBEEF);
        check32("out_port_hi_written", out_word(d, po), 32'hDEADBEEF);
        check32("out_port0_untouched", out_word(d, 0), 32'h0);
        rd(d, io + 32'(po*4), 32'hDEADBEEF);
        wr(d, 4'hF, io + 32'h20, 32'h5);
        check32("in_offset_write_ignored_hi", out_word(d, po), 32'hDEADBEEF);
        check32("in_offset_write_ignored_0", out_word(d, 0), 32'h0);
        rd(d, io + 32'h20, 32'h0);
        rd(d, 32'h0, 32'h11BB33DD);
        wr(d, 4'b0010, io, 32'h1234AB78);
        check32("out_port0_lane1", out_word(d, 0), 32'h0000AB00);

        // Input synchronisation latency, then read-to-clear status
        set_in(d, 0, v0);
        rd(d, io + 32'h20, 32'h0);
        rd(d, io + 32'h20, 32'h0);
        rd(d, io + 32'h20, v0);
        rd(d, io + 32'h40, 32'h1);
        rd(d, io + 32'h40, 32'h0);

        // Change event on the same edge as a status read
        set_in(d, 1, v1);
        rd(d, io + 32'h40, 32'h0);
        rd(d, io + 32'h40, 32'h0);
        rd(d, io + 32'h40, 32'h0);
        rd(d, io + 32'h40, 32'h2);
        rd(d, io + 32'h40, 32'h0);
        rd(d, io + 32'h24, v1);

        // Third input port exists only on the wide instance
        if (d == 1) begin
            set_in(d, 2, 32'h1234);
            rd(d, io + 32'h28, 32'h0);
            rd(d, io + 32'h28, 32'h0);
            rd(d, io + 32'h28, 32'h1234);
            rd(d, io + 32'h40, 32'h4);
        end

        // Unmapped offsets and write to status
        rd(d, io + 32'h3C, 32'h0);
        rd(d, io + 32'h44, 32'h0);
        wr(d, 4'hF, io + 32'h40, 32'hFFFFFFFF);
        rd(d, io + 32'h40, 32'h0);

        // Back-to-back read-after-write on the last RAM word
        wr(d, 4'hF, last, 32'hCAFEF00D);
        rd(d, last, 32'hCAFEF00D);
        wr(d, 4'b0001, last, 32'h000000AB);
        rd(d, last, 32'hCAFEF0AB);
    endtask

    // Scoreboard monitor for the default instance.
    always @(negedge clock) begin
        if (bus_a.rvalid === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rvalid: got rdata %08h expected no rvalid", bus_a.rdata);
            end else begin
                e_a = exp_a.pop_front();
                check32("a_rdata", bus_a.rdata, e_a);
            end
        end
    end

    // Scoreboard monitor for the wide instance.
    always @(negedge clock) begin
        if (bus_b.rvalid === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_rvalid: got rdata %08h expected no rvalid", bus_b.rdata);
            end else begin
                e_b = exp_b.pop_front();
                check32("b_rdata", bus_b.rdata, e_b);
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_a  = '0;
        in_b  = '0;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.be = 4'h0; bus_a.addr = 32'h0; bus_a.wdata = 32'h0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.be = 4'h0; bus_b.addr = 32'h0; bus_b.wdata = 32'h0;
        repeat (3) @(negedge clock);

        check32("reset_rdata_a", bus_a.rdata, 32'h0);
        check32("reset_rvalid_a", 32'(bus_a.rvalid), 32'h0);
        check32("reset_out_a0", out_a[31:0], 32'h0);
        check32("reset_out_b3", out_b[127:96], 32'h0);
        reset = 1'b0;

        suite(0);
        suite(1);

        // Raise change flags on both instances, then reset during accesses
        in_a = '0;
        in_b = '0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.be = 4'hF; bus_a.addr = 32'h80; bus_a.wdata = 32'h1234;
        bus_b.req = 1'b1; bus_b.we = 1'b0; bus_b.be = 4'hF; bus_b.addr = 32'h0;  bus_b.wdata = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
        check32("rst_out_a0", out_a[31:0], 32'h0);
        check32("rst_out_a1", out_a[63:32], 32'h0);
        check32("rst_rdata_a", bus_a.rdata, 32'h0);
        check32("rst_rvalid_b", 32'(bus_b.rvalid), 32'h0);
        check32("rst_rdata_b", bus_b.rdata, 32'h0);
        check32("rst_out_b3", out_b[127:96], 32'h0);
        rd(0, 32'hC0, 32'h0);
        rd(1, 32'h440, 32'h0);
        rd(0, 32'h80, 32'h0);
        rd(0, 32'h0, 32'h11BB33DD);

        repeat (3) @(negedge clock);
        check32("a_queue_drained", 32'(exp_a.size()), 32'h0);
        check32("b_queue_drained", 32'(exp_b.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
